// File: rtl/vn_rng_sched_pkg.sv
// Shared types and defaults for the Von Neumann corrector scheduler.
// Holds the FSM state encoding, default timeout and default budget width.
package vn_rng_sched_pkg;

  localparam int          MBW_DEF  = 12;
  localparam logic [15:0] TOUT_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_GUARD = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/vn_rng_sched_if.sv
// Link between the scheduler and the shared Von Neumann corrector.
// master: scheduler (enable/budget/bypass out, done in); slave: corrector.
interface vn_rng_sched_if
  import vn_rng_sched_pkg::*;
#(
  parameter int MBW = MBW_DEF
);

  logic           vn_enable_p;
  logic [MBW-1:0] vn_maxbits;
  logic           vn_bypass;
  logic           vn_done_p;

  modport master (
    output vn_enable_p,
    output vn_maxbits,
    output vn_bypass,
    input  vn_done_p
  );

  modport slave (
    input  vn_enable_p,
    input  vn_maxbits,
    input  vn_bypass,
    output vn_done_p
  );

endinterface

// File: rtl/vn_rng_sched_rr_arbiter.sv
// Pointer-based round-robin arbiter: first set req at or after ptr wins.
// Ports: req (N), ptr (start index) -> gnt (one-hot), idx (winner index).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  int j;

  // Scan from the farthest offset down so the nearest one is kept.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/vn_rng_sched.sv
// Round-robin scheduler sharing one Von Neumann corrector among NREQ users.
// Ports: clk, rst_n, req/req_maxbits/cfg_bypass in; gnt/rsp_* /busy out; vn link.
module vn_rng_sched
  import vn_rng_sched_pkg::*;
#(
  parameter int          NREQ = 2,
  parameter int          MBW  = MBW_DEF,
  parameter logic [15:0] TOUT = TOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*MBW-1:0] req_maxbits,
  input  logic                cfg_bypass,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_done_p,
  output logic [NREQ-1:0]     rsp_err_p,
  output logic                busy,
  vn_rng_sched_if.master      vn
);

  localparam int          PW      = $clog2(NREQ);
  localparam logic [15:0] TOUT_M1 = TOUT - 16'd1;

  state_t         state;
  state_t         state_n;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  win_idx;
  logic [PW-1:0]  arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [15:0]    cnt;
  logic [MBW-1:0] mb_q;
  logic           byp_q;
  logic [MBW-1:0] win_mb;
  logic           grab;
  logic           fin;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign win_mb = req_maxbits[int'(arb_idx)*MBW +: MBW];
  assign grab   = (state == S_IDLE) && (|req);
  assign fin    = (state == S_DONE) || (state == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Done is only honoured in WAIT; it wins over a same-cycle timeout.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (|req) state_n = S_START;
      S_START: state_n = (mb_q == '0) ? S_DONE : S_GUARD;
      S_GUARD: state_n = S_WAIT;
      S_WAIT: begin
        if (vn.vn_done_p)        state_n = S_DONE;
        else if (cnt == TOUT_M1) state_n = S_ERR;
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      mb_q    <= '0;
      byp_q   <= 1'b0;
      win_idx <= '0;
      ptr     <= '0;
    end else if (grab) begin
      gnt     <= arb_gnt;
      mb_q    <= win_mb;
      byp_q   <= cfg_bypass;
      win_idx <= arb_idx;
    end else if (fin) begin
      gnt <= '0;
      if (int'(win_idx) == NREQ - 1) ptr <= '0;
      else                           ptr <= win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (state == S_GUARD) cnt <= '0;
    else if (state == S_WAIT)  cnt <= cnt + 16'd1;
  end

  assign busy           = (state != S_IDLE);
  assign rsp_done_p     = (state == S_DONE) ? gnt : '0;
  assign rsp_err_p      = (state == S_ERR) ? gnt : '0;
  assign vn.vn_enable_p = (state == S_START) && (mb_q != '0);
  assign vn.vn_maxbits  = mb_q;
  assign vn.vn_bypass   = byp_q;

endmodule

// File: tb/tb_vn_rng_sched.sv
// Randomized self-checking bench for vn_rng_sched (NREQ=2, TOUT=50).
// Expected grants and pulse timing come from a transaction-level model.
module tb_vn_rng_sched;

  localparam int          N    = 2;
  localparam int          MBW  = 12;
  localparam logic [15:0] TOUT = 16'd50;
  localparam int          TO   = 50;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [N*MBW-1:0]   req_maxbits;
  logic               cfg_bypass;
  logic [N-1:0]       gnt;
  logic [N-1:0]       rsp_done_p;
  logic [N-1:0]       rsp_err_p;
  logic               busy;

  vn_rng_sched_if #(.MBW(MBW)) vif ();

  vn_rng_sched #(
    .NREQ (N),
    .MBW  (MBW),
    .TOUT (TOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_maxbits (req_maxbits),
    .cfg_bypass  (cfg_bypass),
    .gnt         (gnt),
    .rsp_done_p  (rsp_done_p),
    .rsp_err_p   (rsp_err_p),
    .busy        (busy),
    .vn          (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    vif.vn_done_p = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    req_maxbits = '0;
    cfg_bypass = 1'b1;
    vif.vn_done_p = 1'b0;
    tick();
    tick();
    checks++;
    if ({gnt, rsp_done_p, rsp_err_p, busy} !== '0) begin
      errors++;
      $display("FAIL reset_out: got gnt=%b done=%b err=%b busy=%b want 0",
               gnt, rsp_done_p, rsp_err_p, busy);
    end
    checks++;
    if ({vif.vn_enable_p, vif.vn_maxbits, vif.vn_bypass} !== '0) begin
      errors++;
      $display("FAIL reset_vn: got en=%b mb=%0d byp=%b want 0",
               vif.vn_enable_p, vif.vn_maxbits, vif.vn_bypass);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_basic();
    int en_cnt;
    en_cnt = 0;
    cfg_bypass = 1'b0;
    req_maxbits[0 +: MBW] = 12'd100;
    req_maxbits[MBW +: MBW] = 12'($urandom);
    req = 2'b01;
    tick();
    en_cnt += int'(vif.vn_enable_p);
    checks++;
    if (gnt !== 2'b01 || vif.vn_maxbits !== 12'd100) begin
      errors++;
      $display("FAIL basic_grant: got gnt=%b mb=%0d want 01/100",
               gnt, vif.vn_maxbits);
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      en_cnt += int'(vif.vn_enable_p);
      if (k == 20) vif.vn_done_p = 1'b1;
    end
    tick();
    vif.vn_done_p = 1'b0;
    checks++;
    if (rsp_done_p !== 2'b01 || rsp_err_p !== 2'b00) begin
      errors++;
      $display("FAIL basic_done: got done=%b err=%b want 01/00",
               rsp_done_p, rsp_err_p);
    end
    checks++;
    if (en_cnt != 1) begin
      errors++;
      $display("FAIL basic_enables: got %0d want 1", en_cnt);
    end
    req = '0;
    m_ptr = 1;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b gnt=%b want 0/00", busy, gnt);
    end
  endtask

  task automatic test_rr();
    int w;
    int d;
    int bad;
    int order[3] = '{0, 1, 0};
    do_reset();
    req_maxbits[0 +: MBW] = 12'($urandom_range(1, 4095));
    req_maxbits[MBW +: MBW] = 12'($urandom_range(1, 4095));
    req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      bad = 0;
      tick();
      w = rr_pick(req, m_ptr);
      checks++;
      if (gnt !== oh(w) || w != order[t]) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", t, gnt, oh(order[t]));
      end
      d = $urandom_range(2, 10);
      for (int k = 0; k < d; k++) begin
        tick();
        if (!$onehot(gnt)) bad++;
      end
      vif.vn_done_p = 1'b1;
      tick();
      vif.vn_done_p = 1'b0;
      if (!$onehot(gnt)) bad++;
      checks++;
      if (rsp_done_p !== oh(w) || bad != 0) begin
        errors++;
        $display("FAIL rr_done%0d: got %b (non-onehot %0d) want %b",
                 t, rsp_done_p, bad, oh(w));
      end
      m_ptr = (w + 1) % N;
      tick();
      if (t == 2) req = '0;
      checks++;
      if (busy !== 1'b0 || gnt !== '0) begin
        errors++;
        $display("FAIL rr_gap%0d: got busy=%b gnt=%b want 0/00",
                 t, busy, gnt);
      end
    end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    req_maxbits[0 +: MBW] = 12'($urandom_range(1, 4095));
    req = 2'b01;
    tick();
    for (int k = 1; k <= TO + 1; k++) begin
      tick();
      if (k == 1) vif.vn_done_p = 1'b1;
      if (k == 2) vif.vn_done_p = 1'b0;
      if (rsp_done_p !== '0 || rsp_err_p !== '0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tout_early: got %0d bad cycles want 0", bad);
    end
    tick();
    checks++;
    if (rsp_err_p !== 2'b01 || rsp_done_p !== 2'b00) begin
      errors++;
      $display("FAIL tout_err: got err=%b done=%b want 01/00",
               rsp_err_p, rsp_done_p);
    end
    m_ptr = 1;
    req = 2'b11;
    tick();
    tick();
    checks++;
    if (gnt !== oh(rr_pick(req, m_ptr))) begin
      errors++;
      $display("FAIL tout_ptr: got %b want %b", gnt, oh(rr_pick(req, m_ptr)));
    end
    repeat (3) tick();
    vif.vn_done_p = 1'b1;
    tick();
    vif.vn_done_p = 1'b0;
    req = '0;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_zero();
    int w;
    req_maxbits[0 +: MBW] = 12'($urandom_range(1, 4095));
    req_maxbits[MBW +: MBW] = '0;
    req = 2'b10;
    w = rr_pick(req, m_ptr);
    tick();
    checks++;
    if (vif.vn_enable_p !== 1'b0 || gnt !== oh(w)) begin
      errors++;
      $display("FAIL zero_start: got en=%b gnt=%b want 0/%b",
               vif.vn_enable_p, gnt, oh(w));
    end
    tick();
    checks++;
    if (rsp_done_p !== 2'b10 || vif.vn_enable_p !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b en=%b want 10/0",
               rsp_done_p, vif.vn_enable_p);
    end
    req = '0;
    m_ptr = (w + 1) % N;
    tick();
  endtask

  task automatic test_done_at_tout();
    int bad;
    bad = 0;
    req_maxbits[0 +: MBW] = 12'($urandom_range(1, 4095));
    req = 2'b01;
    tick();
    for (int k = 1; k <= TO + 1; k++) begin
      tick();
      if (rsp_err_p !== '0 || rsp_done_p !== '0) bad++;
    end
    vif.vn_done_p = 1'b1;
    tick();
    vif.vn_done_p = 1'b0;
    checks++;
    if (rsp_done_p !== 2'b01 || rsp_err_p !== 2'b00 || bad != 0) begin
      errors++;
      $display("FAIL edge_done: got done=%b err=%b bad=%0d want 01/00/0",
               rsp_done_p, rsp_err_p, bad);
    end
    req = '0;
    m_ptr = 1;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]   rq;
    logic [MBW-1:0] mb[N];
    logic           byp;
    int w;
    int d;
    int bad;
    for (int it = 0; it < 10; it++) begin
      bad = 0;
      rq = N'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) begin
        mb[i] = ($urandom_range(0, 3) == 0) ? '0 : 12'($urandom);
        req_maxbits[i*MBW +: MBW] = mb[i];
      end
      byp = 1'($urandom);
      cfg_bypass = byp;
      req = rq;
      w = rr_pick(rq, m_ptr);
      tick();
      cfg_bypass = ~byp;
      checks++;
      if (gnt !== oh(w) || vif.vn_maxbits !== mb[w] ||
          vif.vn_bypass !== byp ||
          vif.vn_enable_p !== (mb[w] != '0)) begin
        errors++;
        $display("FAIL rnd_start%0d: got gnt=%b mb=%0d byp=%b en=%b want %b/%0d/%b",
                 it, gnt, vif.vn_maxbits, vif.vn_bypass, vif.vn_enable_p,
                 oh(w), mb[w], byp);
      end
      if (mb[w] != '0) begin
        d = $urandom_range(2, 12);
        for (int k = 0; k < d; k++) begin
          tick();
          if (vif.vn_enable_p !== 1'b0 || rsp_done_p !== '0) bad++;
          if (vif.vn_bypass !== byp) bad++;
        end
        vif.vn_done_p = 1'b1;
      end
      tick();
      vif.vn_done_p = 1'b0;
      checks++;
      if (rsp_done_p !== oh(w) || rsp_err_p !== '0 || bad != 0) begin
        errors++;
        $display("FAIL rnd_done%0d: got done=%b err=%b bad=%0d want %b",
                 it, rsp_done_p, rsp_err_p, bad, oh(w));
      end
      req = '0;
      m_ptr = (w + 1) % N;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    req_maxbits[0 +: MBW] = 12'($urandom_range(1, 4095));
    req = 2'b01;
    tick();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, rsp_done_p, rsp_err_p, busy, vif.vn_enable_p,
         vif.vn_maxbits, vif.vn_bypass} !== '0) begin
      errors++;
      $display("FAIL rmid_clear: got gnt=%b busy=%b en=%b mb=%0d want 0",
               gnt, busy, vif.vn_enable_p, vif.vn_maxbits);
    end
    tick();
    checks++;
    if (rsp_done_p !== '0 || rsp_err_p !== '0) begin
      errors++;
      $display("FAIL rmid_pulse: got done=%b err=%b want 00/00",
               rsp_done_p, rsp_err_p);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    tick();
    checks++;
    if (vif.vn_enable_p !== 1'b1 || gnt !== 2'b01) begin
      errors++;
      $display("FAIL rmid_restart: got en=%b gnt=%b want 1/01",
               vif.vn_enable_p, gnt);
    end
    repeat (3) tick();
    vif.vn_done_p = 1'b1;
    tick();
    vif.vn_done_p = 1'b0;
    checks++;
    if (rsp_done_p !== 2'b01) begin
      errors++;
      $display("FAIL rmid_done: got %b want 01", rsp_done_p);
    end
    req = '0;
    m_ptr = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rr();
    test_timeout();
    test_zero();
    test_done_at_tout();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
